// File: rtl/mul_seq_ctrl.sv
// Sequencer for an iterative radix-2 shift-add multiplier (RV32M MUL/MULH/MULHSU/MULHU).
// Stalls the pipeline via mul_finish for the whole operation and presents the product in DONE.
`timescale 1ns/1ps
module mul_seq_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_req,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            mul_finish,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_result,
  output logic            busy
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic              r_neg;
  logic              r_sel_hi;
  logic              r_valid;
  logic [XLEN-1:0]   r_result;

  logic              w_start;
  logic              w_sign1;
  logic              w_sign2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN:0]     w_sum;
  logic [PW-1:0]     w_shift;
  logic [PW-1:0]     w_prod;
  logic              w_last;

  assign w_start = (r_state == S_IDLE) & mul_req & ~funct3[2] & ~flush;

  // MULH treats both operands as signed, MULHSU only rs1
  assign w_sign1 = ((funct3[1:0] == 2'd1) | (funct3[1:0] == 2'd2)) & rs1_data[XLEN-1];
  assign w_sign2 = (funct3[1:0] == 2'd1) & rs2_data[XLEN-1];
  assign w_mag1  = w_sign1 ? XLEN'(-rs1_data) : rs1_data;
  assign w_mag2  = w_sign2 ? XLEN'(-rs2_data) : rs2_data;

  // Upper half gets one extra bit so the add carry survives the right shift
  assign w_sum   = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : (XLEN+1)'(0));
  assign w_shift = {w_sum, r_mplier[XLEN-1:1]};
  assign w_prod  = r_neg ? PW'(-w_shift) : w_shift;
  assign w_last  = (r_cnt == CNT_W'(XLEN-1));

  assign mul_finish = ~(w_start | (r_state == S_CALC));
  assign mul_valid  = r_valid;
  assign mul_result = r_result;
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_sel_hi <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid  <= 1'b0;
          r_result <= '0;
          if (w_start) begin
            r_mcand  <= w_mag1;
            r_mplier <= w_mag2;
            r_neg    <= w_sign1 ^ w_sign2;
            r_sel_hi <= (funct3 != 3'd0);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_acc    <= w_shift[PW-1:XLEN];
            r_mplier <= w_shift[XLEN-1:0];
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= r_sel_hi ? w_prod[PW-1:XLEN] : w_prod[XLEN-1:0];
            end
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_valid  <= 1'b0;
          r_result <= '0;
          if (flush) begin
            r_acc    <= '0;
            r_mplier <= '0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_valid  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner cases plus random operands
// compared against a 64-bit arithmetic reference of the RV32M multiply semantics.
`timescale 1ns/1ps
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_req;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        mul_finish;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mul_seq_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_req    (mul_req),
    .funct3     (funct3),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .mul_finish (mul_finish),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    logic [63:0] ea, eb, p;
    ea = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one multiply at the current negedge; returns at the negedge of the cycle after DONE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input bit hold);
    int stall;
    int bad_out;
    bit seen;
    logic [31:0] exp;
    exp      = ref_mul(a, b, f3);
    mul_req  = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    #1;
    check("start_stall", 32'(mul_finish), 32'd0);
    stall   = 0;
    bad_out = 0;
    seen    = 1'b0;
    for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
      if (!mul_finish) stall++;
      if (mul_valid) seen = 1'b1;
      else begin
        if (mul_result !== 32'h0) bad_out++;
        @(negedge clk);
        rs1_data = $urandom;
        rs2_data = $urandom;
        #1;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("stall_cycles", 32'(stall), 32'd33);
    check("result_idle_zero", 32'(bad_out), 32'd0);
    check("result", mul_result, exp);
    check("done_finish", 32'(mul_finish), 32'd1);
    if (!hold) mul_req = 1'b0;
    @(negedge clk);
    #1;
    check("post_valid", 32'(mul_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_result", mul_result, 32'h0);
    check("post_finish", 32'(mul_finish), hold ? 32'd0 : 32'd1);
  endtask

  // Start a MUL, then abort it at CALC cycle 'at' by flush or by reset.
  task automatic abort_mul(input bit use_rst, input int at);
    int vcnt;
    mul_req  = 1'b1;
    funct3   = 3'd0;
    rs1_data = 32'd1234;
    rs2_data = 32'd5678;
    repeat (at) @(negedge clk);
    #1;
    check(use_rst ? "rst_pre_busy" : "flush_pre_busy", 32'(busy), 32'd1);
    mul_req = 1'b0;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    check(use_rst ? "rst_busy" : "flush_busy", 32'(busy), 32'd0);
    check(use_rst ? "rst_finish" : "flush_finish", 32'(mul_finish), 32'd1);
    check(use_rst ? "rst_valid" : "flush_valid", 32'(mul_valid), 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (mul_valid || busy) vcnt++;
    end
    check(use_rst ? "rst_no_late_valid" : "flush_no_late_valid", 32'(vcnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int fin_low;
    logic [31:0] ra, rb;
    logic [2:0]  rf;

    rst = 1'b1; mul_req = 1'b0; funct3 = 3'd0; flush = 1'b0;
    rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_finish0", 32'(mul_finish), 32'd1);
    check("rst_valid0", 32'(mul_valid), 32'd0);
    check("rst_result0", mul_result, 32'h0);
    check("rst_busy0", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_mul(32'd7, 32'd6, 3'd0, 1'b0);
    run_mul(32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0);
    check("mulh_min_literal", ref_mul(32'h8000_0000, 32'hFFFF_FFFF, 3'd1), 32'h0);

    // back-to-back with mul_req held across DONE
    run_mul(32'd100, 32'd3, 3'd0, 1'b1);
    run_mul(32'd9, 32'd9, 3'd0, 1'b0);
    run_mul(32'h1234_5678, 32'd0, 3'd0, 1'b0);

    abort_mul(1'b0, 10);
    abort_mul(1'b1, 20);

    // DIV-class funct3 is ignored
    mul_req = 1'b1; funct3 = 3'd4; rs1_data = 32'd50; rs2_data = 32'd5;
    busy_cnt = 0; fin_low = 0;
    repeat (6) begin
      #1;
      if (busy) busy_cnt++;
      if (!mul_finish) fin_low++;
      @(negedge clk);
    end
    check("div_busy", 32'(busy_cnt), 32'd0);
    check("div_finish", 32'(fin_low), 32'd0);

    // flush while idle suppresses start
    funct3 = 3'd0; flush = 1'b1;
    #1;
    check("idle_flush_finish", 32'(mul_finish), 32'd1);
    @(negedge clk);
    #1;
    check("idle_flush_busy", 32'(busy), 32'd0);
    flush = 1'b0; mul_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 3'($urandom_range(0, 3));
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h8000_0000;
      run_mul(ra, rb, rf, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
